// File: rtl/autocorr_engine.sv
// Frame autocorrelation engine: r[k] = sum x[n]*x[n-k], k=0..P, one multiply per cycle.
// Feeds a downstream Levinson datapath through a one-hot lag-select read port.
module autocorr_engine #(
   parameter int N  = 160,
   parameter int P  = 10,
   parameter int DW = 16,
   parameter int AW = 40
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   input  logic [P:0]           r_rsel,
   output logic [AW-1:0]        r_data,
   output logic                 ready,
   output logic                 busy
);

   // state | meaning
   // IDLE  | waiting for start, accumulators held
   // LOAD  | in_ready high, waiting for the next sample
   // MAC   | accumulating h[0]*h[k] for k = 0..P, one lag per cycle
   // DONE  | r[0..P] valid and held, ready high
   typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;

   localparam int KW = $clog2(P + 1);
   localparam int CW = $clog2(N + 1);
   localparam logic [KW-1:0] K_LAST   = KW'(P);
   localparam logic [CW-1:0] CNT_LAST = CW'(N);

   state_t                r_state;
   logic signed [DW-1:0]  r_hist [0:P];
   logic signed [AW-1:0]  r_acc  [0:P];
   logic [CW-1:0]         r_cnt;
   logic [KW-1:0]         r_k;
   logic                  r_in_ready;
   logic                  r_ready;
   logic                  r_busy;

   logic signed [2*DW-1:0] w_h0;
   logic signed [2*DW-1:0] w_hk;
   logic signed [2*DW-1:0] w_prod;
   logic signed [AW-1:0]   w_prod_ext;
   logic [AW-1:0]          w_rdata;

   // Operands widened first so the single multiplier yields the full 2*DW product
   assign w_h0       = {{DW{r_hist[0][DW-1]}}, r_hist[0]};
   assign w_hk       = {{DW{r_hist[r_k][DW-1]}}, r_hist[r_k]};
   assign w_prod     = w_h0 * w_hk;
   assign w_prod_ext = {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_k        <= '0;
         r_in_ready <= 1'b0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         for (int i = 0; i <= P; i++) begin
            r_acc[i]  <= '0;
            r_hist[i] <= '0;
         end
      end else begin
         unique case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state    <= LOAD;
                  r_cnt      <= '0;
                  r_k        <= '0;
                  r_in_ready <= 1'b1;
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
                  for (int i = 0; i <= P; i++) begin
                     r_acc[i]  <= '0;
                     r_hist[i] <= '0;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  r_hist[0] <= in_data;
                  for (int i = 1; i <= P; i++) begin
                     r_hist[i] <= r_hist[i-1];
                  end
                  r_cnt      <= r_cnt + 1'b1;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= MAC;
               end
            end
            MAC: begin
               r_acc[r_k] <= r_acc[r_k] + w_prod_ext;
               if (r_k == K_LAST) begin
                  if (r_cnt == CNT_LAST) begin
                     r_state <= DONE;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state    <= LOAD;
                     r_in_ready <= 1'b1;
                  end
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Zero-hot or multi-hot selects read as zero rather than an OR of lags
   always_comb begin
      w_rdata = '0;
      if ($onehot(r_rsel)) begin
         for (int i = 0; i <= P; i++) begin
            if (r_rsel[i]) begin
               w_rdata = r_acc[i];
            end
         end
      end
   end

   assign r_data   = w_rdata;
   assign in_ready = r_in_ready;
   assign ready    = r_ready;
   assign busy     = r_busy;

endmodule

// File: doc/autocorr_engine.md
AUTOCORR_ENGINE -- requirements
Module: autocorr_engine

Interface
REQ-001 Parameter N, default 160: samples per analysis frame.
REQ-002 Parameter P, default 10: prediction order; lags 0..P are produced.
REQ-003 Parameter DW, default 16: signed sample width.
REQ-004 Parameter AW, default 40: signed accumulator and result width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a new frame.
REQ-008 in_valid  input  1  in_data holds a valid sample.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 in_data  input  DW  signed sample x[n].
REQ-011 r_rsel  input  P+1  one-hot lag select from the downstream Levinson datapath.
REQ-012 r_data  output  AW  selected autocorrelation value r[k].
REQ-013 ready  output  1  all r[0..P] are valid and held.
REQ-014 busy  output  1  frame in progress, i.e. state LOAD or MAC.

Function
REQ-015 The block SHALL compute r[k] = sum over n=0..N-1 of x[n]*x[n-k] for k=0..P, with x[m]=0 for m<0.
REQ-016 The FSM SHALL have the states IDLE, LOAD, MAC and DONE.
REQ-017 IDLE or DONE with start=1: clear all accumulators and the P-deep sample history, clear the sample counter, go to LOAD.
REQ-018 start SHALL be ignored in LOAD and MAC.
REQ-019 LOAD: in_ready=1; when in_valid=1, accept in_data.
- Shift the history: h[0] <= in_data, h[k] <= h[k-1].
- Increment the sample counter; set k=0; go to MAC.
- With in_valid=0, remain in LOAD.
REQ-020 MAC: in_ready=0; each cycle perform acc[k] <= acc[k] + h[0]*h[k] and k <= k+1; exactly one multiply per cycle.
REQ-021 MAC with k==P: after the final accumulate, go to DONE if the sample count is N, else go to LOAD.
REQ-022 Throughput SHALL be one sample per P+2 cycles with in_valid held high: 1 LOAD cycle plus P+1 MAC cycles.
REQ-023 ready SHALL assert the cycle after the last MAC of sample N, and hold in DONE until start or reset.
REQ-024 Arithmetic widths:
- Product: full 2*DW-bit signed, sign-extended to AW before accumulation.
- No saturation; AW covers N*2^(2*DW-2) without overflow.
REQ-025 r_data SHALL be the combinational read of acc[k] for one-hot r_rsel bit k, valid in any state.
REQ-026 r_data SHALL be 0 when r_rsel is zero-hot or multi-hot.
REQ-027 Accumulators SHALL be stable (unchanged) in DONE and IDLE.
REQ-028 start in DONE: ready and the accumulators clear on the next cycle.

Reset
REQ-029 On reset=1 at a clock edge, the following SHALL take effect on the next cycle, overriding all else including mid-MAC:
- state=IDLE; in_ready=0, ready=0, busy=0.
- All accumulators, history, sample counter and k = 0; hence r_data=0.
REQ-030 A frame interrupted by reset SHALL be discarded; no partial result is retained.

Verification
REQ-031 Constant frame: reset, start, 160 samples all +1 with in_valid held high -> r[k]=160-k (r[0]=160, r[10]=150). ready rises exactly 160*12 cycles after the LOAD entry cycle.
REQ-032 Impulse: x[0]=1000, x[1..159]=0 -> r[0]=1,000,000 and r[1..10]=0.
REQ-033 Extreme value: all 160 samples = -32768 -> r[0]=171,798,691,840 and r[10]=161,061,273,600, with no wrap.
REQ-034 Backpressure: in_valid random at 30% -> results identical to REQ-031; in_ready is never high during MAC; no sample is lost or duplicated.
REQ-035 Reset mid-frame: reset during MAC of sample 50 -> next cycle in_ready=0, ready=0, r_data=0 for every one-hot r_rsel. A subsequent start and full frame gives correct results.
REQ-036 start pulsed during MAC is ignored (count still 160). start in DONE -> ready=0 next cycle and r_data=0. Bad r_rsel (0x000 or 0x003) -> r_data=0.
